// File: rtl/uart_cmd_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared constants and types for the UART command sequencer.
//   - Request opcodes and response codes (byte 0 of a frame).
//   - FSM state enum.
//   - Default frame size in bytes.
// ----------------------------------------------------------------------------
package uart_cmd_pkg;

  localparam int DEF_FRAME_BYTES = 18;

  // Request opcodes
  localparam logic [7:0] OP_ECHO    = 8'h01;
  localparam logic [7:0] OP_COMPUTE = 8'h02;
  localparam logic [7:0] OP_STATUS  = 8'h03;

  // Response codes
  localparam logic [7:0] RSP_COMPUTE = 8'h82;
  localparam logic [7:0] RSP_STATUS  = 8'h83;
  localparam logic [7:0] RSP_BADOP   = 8'hEE;
  localparam logic [7:0] RSP_TIMEOUT = 8'hEF;
  localparam logic [7:0] RSP_BADSUM  = 8'hEC;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_DECODE      = 3'd1,
    ST_DISPATCH    = 3'd2,
    ST_WAIT_RESULT = 3'd3,
    ST_SEND        = 3'd4,
    ST_WAIT_TX     = 3'd5
  } state_t;

  // Every error response code lives in the 0xE0..0xEF range.
  function automatic logic is_error_code(input logic [7:0] code);
    return code[7:4] == 4'hE;
  endfunction

endpackage

// File: rtl/uart_cmd_sequencer_xor.sv
// ----------------------------------------------------------------------------
// uart_frame_xor
// Combinational XOR of bytes 0..FRAME_BYTES-2 of a frame (the last byte is the
// checksum slot itself and is excluded). Only built when CMD_SEQ_CHECKSUM_EN
// is defined.
// Ports:
//   frame  in  FRAME_BYTES*8  frame to reduce
//   sum    out 8              XOR of bytes 0..FRAME_BYTES-2
// ----------------------------------------------------------------------------
`ifdef CMD_SEQ_CHECKSUM_EN
module uart_frame_xor #(
  parameter int FRAME_BYTES = 18
) (
  input  logic [FRAME_BYTES*8-1:0] frame,
  output logic [7:0]               sum
);

  // The checksum slot does not take part in its own reduction.
  logic unused_sum_slot;
  assign unused_sum_slot = ^frame[FRAME_BYTES*8-1 -: 8];

  always_comb begin
    sum = '0;
    for (int k = 0; k < FRAME_BYTES - 1; k++) begin
      sum = sum ^ frame[8*k +: 8];
    end
  end

endmodule
`endif

// File: rtl/uart_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// uart_cmd_sequencer
// Pops one received frame at a time, decodes byte 0 and answers it:
//   ECHO    -> request returned unchanged
//   STATUS  -> 0x83, tag, frames_ok, frames_err
//   COMPUTE -> request sent to the coprocessor, result returned as 0x82
//   other   -> 0xEE error with the offending opcode
// The response is then handed to the UART transmitter with a one-cycle pulse.
//
// Build option: CMD_SEQ_CHECKSUM_EN -- request byte 17 is checked against the
// XOR of bytes 0..16 (mismatch -> 0xEC error) and every response gets byte 17
// rewritten with its own XOR. Without it byte 17 is plain payload.
//
// Ports:
//   clk_100MHz   in   system clock
//   reset        in   synchronous, active-high
//   rx_empty     in   no received frame pending
//   rx_frame     in   head-of-queue received frame
//   rx_pop       out  consumes the head frame (one cycle)
//   tx_ready     in   transmitter can accept a frame
//   tx_trigger   out  one-cycle send pulse
//   tx_frame     out  response frame, stable from trigger onward
//   cop_valid    out  coprocessor request valid
//   cop_ready    in   coprocessor accepts the request
//   cop_op       out  sub-operation (request byte 1)
//   cop_operand  out  request bytes 2..17
//   cop_done     in   result strobe
//   cop_result   in   result payload, sampled on cop_done
//   busy         out  FSM not in IDLE
//   frames_ok    out  saturating count of successful responses
//   frames_err   out  saturating count of error responses
//   state_dbg    out  current FSM state (state_t encoding)
//
// Coprocessor handshake: a request transfers on the rising edge where
// cop_valid && cop_ready are both high. cop_valid, cop_op and cop_operand are
// held stable until that edge and cop_valid drops right after it; cop_valid
// never depends combinationally on cop_ready.
// ----------------------------------------------------------------------------
module uart_cmd_sequencer
  import uart_cmd_pkg::*;
#(
  parameter int FRAME_BYTES    = DEF_FRAME_BYTES,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int CNT_W          = 16
) (
  input  logic                         clk_100MHz,
  input  logic                         reset,
  input  logic                         rx_empty,
  input  logic [FRAME_BYTES*8-1:0]     rx_frame,
  output logic                         rx_pop,
  input  logic                         tx_ready,
  output logic                         tx_trigger,
  output logic [FRAME_BYTES*8-1:0]     tx_frame,
  output logic                         cop_valid,
  input  logic                         cop_ready,
  output logic [7:0]                   cop_op,
  output logic [(FRAME_BYTES-2)*8-1:0] cop_operand,
  input  logic                         cop_done,
  input  logic [(FRAME_BYTES-2)*8-1:0] cop_result,
  output logic                         busy,
  output logic [CNT_W-1:0]             frames_ok,
  output logic [CNT_W-1:0]             frames_err,
  output logic [2:0]                   state_dbg
);

  localparam int FW = FRAME_BYTES * 8;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [FW-1:0]   req;
  logic [FW-1:0]   rsp;
  logic [TW-1:0]   tcnt;

  logic [7:0]      req_op;
  logic [7:0]      req_b1;
  logic [15:0]     ok16;
  logic [15:0]     err16;
  logic            timeout_hit;
  logic            sum_ok;
  logic [FW-1:0]   dec_rsp;
  logic [FW-1:0]   tmo_rsp;
  logic [FW-1:0]   tx_next;

  assign req_op      = req[7:0];
  assign req_b1      = req[15:8];
  assign ok16        = 16'(frames_ok);
  assign err16       = 16'(frames_err);
  assign timeout_hit = (tcnt == T_LAST);

  // Pop is issued in the same cycle the head frame is latched, so the frame
  // source advances on exactly the edge that captures it.
  assign rx_pop    = (state == ST_IDLE) && !rx_empty && !reset;
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

`ifdef CMD_SEQ_CHECKSUM_EN
  logic [7:0] req_xor;
  logic [7:0] rsp_xor;

  uart_frame_xor #(.FRAME_BYTES(FRAME_BYTES)) u_check_xor (
    .frame (req),
    .sum   (req_xor)
  );

  uart_frame_xor #(.FRAME_BYTES(FRAME_BYTES)) u_gen_xor (
    .frame (rsp),
    .sum   (rsp_xor)
  );

  assign sum_ok  = (req_xor == req[FW-1 -: 8]);
  assign tx_next = {rsp_xor, rsp[FW-9:0]};
`else
  assign sum_ok  = 1'b1;
  assign tx_next = rsp;
`endif

  // Locally answered responses, built from the latched request.
  always_comb begin
    dec_rsp = '0;
    if (!sum_ok) begin
      dec_rsp[7:0]  = RSP_BADSUM;
      dec_rsp[15:8] = req[FW-1 -: 8];
    end else begin
      case (req_op)
        OP_ECHO: dec_rsp = req;
        OP_COMPUTE: dec_rsp = '0;
        OP_STATUS: begin
          dec_rsp[7:0]   = RSP_STATUS;
          dec_rsp[15:8]  = req_b1;
          dec_rsp[31:16] = ok16;
          dec_rsp[47:32] = err16;
        end
        default: begin
          dec_rsp[7:0]  = RSP_BADOP;
          dec_rsp[15:8] = req_op;
        end
      endcase
    end
  end

  always_comb begin
    tmo_rsp       = '0;
    tmo_rsp[7:0]  = RSP_TIMEOUT;
    tmo_rsp[15:8] = OP_COMPUTE;
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state       <= ST_IDLE;
      req         <= '0;
      rsp         <= '0;
      tcnt        <= '0;
      tx_trigger  <= 1'b0;
      tx_frame    <= '0;
      cop_valid   <= 1'b0;
      cop_op      <= '0;
      cop_operand <= '0;
      frames_ok   <= '0;
      frames_err  <= '0;
    end else begin
      tx_trigger <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rx_empty) begin
            req   <= rx_frame;
            state <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          rsp <= dec_rsp;
          if (sum_ok && req_op == OP_COMPUTE) begin
            cop_op      <= req_b1;
            cop_operand <= req[FW-1:16];
            cop_valid   <= 1'b1;
            tcnt        <= '0;
            state       <= ST_DISPATCH;
          end else begin
            state <= ST_SEND;
          end
        end

        // The timeout budget spans DISPATCH and WAIT_RESULT together.
        ST_DISPATCH: begin
          if (timeout_hit) begin
            cop_valid <= 1'b0;
            rsp       <= tmo_rsp;
            state     <= ST_SEND;
          end else begin
            tcnt <= tcnt + 1'b1;
            if (cop_valid && cop_ready) begin
              cop_valid <= 1'b0;
              state     <= ST_WAIT_RESULT;
            end
          end
        end

        // cop_done has priority over a timeout landing in the same cycle.
        ST_WAIT_RESULT: begin
          if (cop_done) begin
            rsp   <= {cop_result, cop_op, RSP_COMPUTE};
            state <= ST_SEND;
          end else if (timeout_hit) begin
            rsp   <= tmo_rsp;
            state <= ST_SEND;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        ST_SEND: begin
          if (tx_ready) begin
            tx_trigger <= 1'b1;
            tx_frame   <= tx_next;
            if (is_error_code(rsp[7:0])) begin
              if (frames_err != '1) frames_err <= frames_err + 1'b1;
            end else begin
              if (frames_ok != '1) frames_ok <= frames_ok + 1'b1;
            end
            state <= ST_WAIT_TX;
          end
        end

        // Leave only once the transmitter has shown it took the frame by
        // dropping tx_ready, so a lingering ready cannot cause a second send.
        ST_WAIT_TX: begin
          if (!tx_ready) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_uart_cmd_sequencer
// Directed bench for uart_cmd_sequencer. Frames are queued to a small rx
// source model; a transmitter model and a coprocessor model answer the DUT.
// Expected responses are pushed to exp_q when a frame is issued and a monitor
// pops and compares them on every tx_trigger pulse.
// ----------------------------------------------------------------------------
module tb_uart_cmd_sequencer;

  localparam int FB = 18;
  localparam int FW = FB * 8;
  localparam int OW = (FB - 2) * 8;
  localparam int TMO = 16;

  // ---------------- clock / reset ----------------
  logic clk_100MHz;
  logic reset;
  int   cyc = 0;

  initial begin
    clk_100MHz = 1'b0;
    forever #5 clk_100MHz = ~clk_100MHz;
  end

  initial forever begin
    @(posedge clk_100MHz);
    cyc++;
  end

  // ---------------- DUT ----------------
  logic          rx_empty;
  logic [FW-1:0] rx_frame;
  logic          rx_pop;
  logic          tx_ready;
  logic          tx_trigger;
  logic [FW-1:0] tx_frame;
  logic          cop_valid;
  logic          cop_ready;
  logic [7:0]    cop_op;
  logic [OW-1:0] cop_operand;
  logic          cop_done;
  logic [OW-1:0] cop_result;
  logic          busy;
  logic [15:0]   frames_ok;
  logic [15:0]   frames_err;
  logic [2:0]    state_dbg;

  uart_cmd_sequencer #(
    .FRAME_BYTES    (FB),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (16)
  ) dut (
    .clk_100MHz  (clk_100MHz),
    .reset       (reset),
    .rx_empty    (rx_empty),
    .rx_frame    (rx_frame),
    .rx_pop      (rx_pop),
    .tx_ready    (tx_ready),
    .tx_trigger  (tx_trigger),
    .tx_frame    (tx_frame),
    .cop_valid   (cop_valid),
    .cop_ready   (cop_ready),
    .cop_op      (cop_op),
    .cop_operand (cop_operand),
    .cop_done    (cop_done),
    .cop_result  (cop_result),
    .busy        (busy),
    .frames_ok   (frames_ok),
    .frames_err  (frames_err),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] rx_q[$];
  int pop_log[$];
  int trig_log[$];
  int n_cmp = 0;
  int n_err = 0;
  int pop_cnt = 0;
  int trig_cnt = 0;
  int hs_cnt = 0;

  // model controls (written only by the main process)
  int tx_block = 0;
  int cop_wait = 0;
  int cop_answer = 1;
  int stray_at = -1;

  task automatic check_f(input string name, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_n(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- frame helpers ----------------
  function automatic logic [FW-1:0] seal(input logic [FW-1:0] f);
    logic [FW-1:0] r;
    r = f;
`ifdef CMD_SEQ_CHECKSUM_EN
    begin
      logic [7:0] s;
      s = '0;
      for (int k = 0; k < FB - 1; k++) s = s ^ f[8*k +: 8];
      r[FW-1 -: 8] = s;
    end
`endif
    return r;
  endfunction

  function automatic logic [FW-1:0] ramp(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] start);
    logic [FW-1:0] r;
    r = '0;
    r[7:0]  = b0;
    r[15:8] = b1;
    for (int k = 2; k < FB; k++) r[8*k +: 8] = start + 8'(k - 2);
    return r;
  endfunction

  function automatic logic [FW-1:0] rsp2(input logic [7:0] b0, input logic [7:0] b1);
    logic [FW-1:0] r;
    r = '0;
    r[7:0]  = b0;
    r[15:8] = b1;
    return r;
  endfunction

  // ---------------- rx source model ----------------
  initial begin
    logic pop_pend;
    pop_pend = 1'b0;
    forever begin
      @(posedge clk_100MHz);
      #1;
      if (pop_pend) begin
        if (rx_q.size() > 0) void'(rx_q.pop_front());
        pop_pend = 1'b0;
      end
      rx_empty = (rx_q.size() == 0);
      if (rx_q.size() > 0) rx_frame = rx_q[0];
      @(negedge clk_100MHz);
      if (rx_pop) begin
        pop_pend = 1'b1;
        pop_cnt++;
        pop_log.push_back(cyc);
      end
    end
  end

  // ---------------- transmitter model ----------------
  initial begin
    int tx_busy;
    tx_busy = 0;
    forever begin
      @(negedge clk_100MHz);
      if (tx_trigger) tx_busy = 3;
      else if (tx_busy > 0) tx_busy--;
      tx_ready = (tx_busy == 0) && (tx_block == 0);
    end
  end

  // ---------------- coprocessor model ----------------
  initial begin
    int wait_left;
    int pend_cnt;
    logic pend;
    logic prev_v;
    wait_left = 0;
    pend_cnt = 0;
    pend = 1'b0;
    prev_v = 1'b0;
    forever begin
      @(negedge clk_100MHz);
      cop_done = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          cop_done = (cop_answer != 0);
          pend = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      if (stray_at == cyc) cop_done = 1'b1;
      if (cop_valid && !prev_v) wait_left = cop_wait;
      prev_v = cop_valid;
      if (cop_valid && wait_left > 0) begin
        cop_ready = 1'b0;
        wait_left--;
      end else if (cop_valid) begin
        // ready is high with valid across the next rising edge: one transfer
        cop_ready = 1'b1;
        hs_cnt++;
        pend = 1'b1;
        pend_cnt = 2;
      end else begin
        cop_ready = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  initial forever begin
    @(negedge clk_100MHz);
    if (tx_trigger) begin
      trig_cnt++;
      trig_log.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_trigger: got frame %h expected no trigger", tx_frame);
      end else begin
        check_f("tx_frame", tx_frame, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_frame(input logic [FW-1:0] f, input logic [FW-1:0] exp, input bit has_exp);
    @(negedge clk_100MHz);
    if (has_exp) exp_q.push_back(exp);
    rx_q.push_back(f);
  endtask

  task automatic wait_trigs(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (trig_cnt < target && n < budget) begin
      @(negedge clk_100MHz);
      n++;
    end
    check_n(name, trig_cnt, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_n({tag, "_rx_pop"}, 32'(rx_pop), 0);
    check_n({tag, "_tx_trigger"}, 32'(tx_trigger), 0);
    check_n({tag, "_cop_valid"}, 32'(cop_valid), 0);
    check_n({tag, "_busy"}, 32'(busy), 0);
    check_f({tag, "_tx_frame"}, tx_frame, '0);
    check_n({tag, "_cop_op"}, 32'(cop_op), 0);
    check_f({tag, "_cop_operand"}, FW'(cop_operand), '0);
    check_n({tag, "_frames_ok"}, 32'(frames_ok), 0);
    check_n({tag, "_frames_err"}, 32'(frames_err), 0);
    check_n({tag, "_state"}, 32'(state_dbg), 0);
  endtask

  task automatic do_reset();
    @(negedge clk_100MHz);
    reset = 1'b1;
    repeat (2) @(negedge clk_100MHz);
    reset = 1'b0;
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    logic [FW-1:0] f;
    logic [FW-1:0] f2;
    logic [FW-1:0] e;
    int p0;
    int t0;
    int h0;
    int n;

    reset      = 1'b1;
    rx_empty   = 1'b1;
    rx_frame   = '0;
    tx_ready   = 1'b1;
    cop_ready  = 1'b0;
    cop_done   = 1'b0;
    cop_result = {(FB-2){8'hA5}};

    repeat (3) @(negedge clk_100MHz);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk_100MHz);

    // ECHO: bytes 1..17 = 0x10..0x20
    f = seal(ramp(8'h01, 8'h10, 8'h11));
    p0 = pop_cnt;
    t0 = trig_cnt;
    send_frame(f, f, 1'b1);
    wait_trigs(t0 + 1, 100, "echo_trigger");
    repeat (3) @(negedge clk_100MHz);
    check_n("echo_pops", pop_cnt - p0, 1);
    check_n("echo_latency", trig_log[t0] - pop_log[p0], 3);
    check_n("echo_frames_ok", 32'(frames_ok), 1);
    check_n("echo_frames_err", 32'(frames_err), 0);

    // COMPUTE: ready held low 4 cycles, result 0xA5 repeated
    cop_wait = 4;
    cop_answer = 1;
    h0 = hs_cnt;
    t0 = trig_cnt;
    f = seal(ramp(8'h02, 8'h05, 8'h40));
    e = seal({{(FB-2){8'hA5}}, 8'h05, 8'h82});
    send_frame(f, e, 1'b1);
    wait_trigs(t0 + 1, 100, "compute_trigger");
    repeat (3) @(negedge clk_100MHz);
    check_n("compute_handshakes", hs_cnt - h0, 1);
    check_n("compute_cop_op", 32'(cop_op), 32'h05);
    check_f("compute_operand", FW'(cop_operand), FW'(f[FW-1:16]));
    check_n("compute_frames_ok", 32'(frames_ok), 2);

    // Timeout: coprocessor accepts but never answers
    cop_wait = 0;
    cop_answer = 0;
    t0 = trig_cnt;
    f = seal(ramp(8'h02, 8'h09, 8'h60));
    send_frame(f, seal(rsp2(8'hEF, 8'h02)), 1'b1);
    wait_trigs(t0 + 1, 100, "timeout_trigger");
    repeat (3) @(negedge clk_100MHz);
    check_n("timeout_frames_err", 32'(frames_err), 1);
    check_n("timeout_frames_ok", 32'(frames_ok), 2);
    check_n("timeout_cop_valid", 32'(cop_valid), 0);
    stray_at = cyc + 2;
    repeat (6) @(negedge clk_100MHz);
    check_n("stray_done_busy", 32'(busy), 0);
    check_n("stray_done_trigs", trig_cnt, t0 + 1);
    check_n("stray_done_frames_ok", 32'(frames_ok), 2);

    // Bad opcode then STATUS, from a fresh reset
    do_reset();
    cop_answer = 1;
    t0 = trig_cnt;
    e = rsp2(8'h83, 8'h33);
    e[31:16] = 16'h0000;
    e[47:32] = 16'h0001;
    send_frame(seal(ramp(8'h7F, 8'h01, 8'h02)), seal(rsp2(8'hEE, 8'h7F)), 1'b1);
    send_frame(seal(ramp(8'h03, 8'h33, 8'h00)), seal(e), 1'b1);
    wait_trigs(t0 + 2, 200, "badop_status_trigger");
    repeat (3) @(negedge clk_100MHz);
    check_n("badop_status_frames_ok", 32'(frames_ok), 1);
    check_n("badop_status_frames_err", 32'(frames_err), 1);

    // Back-to-back frames with transmitter held off for 20 cycles
    tx_block = 1;
    repeat (2) @(negedge clk_100MHz);
    p0 = pop_cnt;
    t0 = trig_cnt;
    f  = seal(ramp(8'h01, 8'hAA, 8'h70));
    f2 = seal(ramp(8'h01, 8'hBB, 8'h90));
    send_frame(f, f, 1'b1);
    send_frame(f2, f2, 1'b1);
    repeat (20) @(negedge clk_100MHz);
    check_n("hold_no_trigger", trig_cnt, t0);
    check_n("hold_single_pop", pop_cnt, p0 + 1);
    tx_block = 0;
    wait_trigs(t0 + 2, 100, "b2b_trigger");
    repeat (3) @(negedge clk_100MHz);
    check_n("b2b_pops", pop_cnt, p0 + 2);
    check_n("b2b_pop_after_wait_tx", (pop_log[p0+1] > trig_log[t0]) ? 1 : 0, 1);
    check_n("b2b_frames_ok", 32'(frames_ok), 3);

    // Reset while waiting for a coprocessor result
    cop_answer = 0;
    h0 = hs_cnt;
    t0 = trig_cnt;
    send_frame(seal(ramp(8'h02, 8'h07, 8'h20)), '0, 1'b0);
    n = 0;
    while (hs_cnt == h0 && n < 50) begin
      @(negedge clk_100MHz);
      n++;
    end
    check_n("midreset_handshake", hs_cnt - h0, 1);
    repeat (2) @(negedge clk_100MHz);
    check_n("midreset_in_wait_result", 32'(state_dbg), 3);
    reset = 1'b1;
    @(negedge clk_100MHz);
    check_reset_outputs("midreset");
    reset = 1'b0;
    p0 = pop_cnt;
    repeat (30) @(negedge clk_100MHz);
    check_n("midreset_no_trigger", trig_cnt, t0);
    check_n("midreset_no_pop", pop_cnt, p0);
    check_n("midreset_idle", 32'(busy), 0);
    cop_answer = 1;

`ifdef CMD_SEQ_CHECKSUM_EN
    // Wrong checksum, then correct checksum
    t0 = trig_cnt;
    f = seal(ramp(8'h01, 8'h10, 8'h11));
    f2 = f;
    f2[FW-1 -: 8] = f[FW-1 -: 8] ^ 8'h5A;
    send_frame(f2, seal(rsp2(8'hEC, f2[FW-1 -: 8])), 1'b1);
    send_frame(f, f, 1'b1);
    wait_trigs(t0 + 2, 200, "checksum_trigger");
    repeat (3) @(negedge clk_100MHz);
    check_n("checksum_frames_err", 32'(frames_err), 1);
    check_n("checksum_frames_ok", 32'(frames_ok), 1);
`endif

    repeat (5) @(negedge clk_100MHz);
    check_n("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: got timeout at cycle %0d expected completion", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_cmd_sequencer.md
Name: uart_cmd_sequencer

Overview:
Command sequencer between the UART frame core and the coprocessor datapath. It pops one received 18-byte frame at a time and decodes the opcode in byte 0. ECHO and STATUS are answered locally; COMPUTE is dispatched to the coprocessor over a valid/ready handshake. The block then builds an 18-byte response frame and triggers UART transmit.

Parameters:
- FRAME_BYTES, 18, bytes per UART frame; byte k occupies bits [8k+7:8k]; byte 0 is the opcode.
- TIMEOUT_CYCLES, 1_000_000, maximum cycles to wait for cop_done before an error response.
- CNT_W, 16, width of the saturating frame counters.

Ports:
- clk_100MHz  in  1  system clock
- reset  in  1  synchronous, active-high
- rx_empty  in  1  high when no received frame is pending
- rx_frame  in  FRAME_BYTES*8  head-of-queue received frame
- rx_pop  out  1  one-cycle pulse that consumes the head frame
- tx_ready  in  1  UART transmitter can accept a frame
- tx_trigger  out  1  one-cycle send pulse
- tx_frame  out  FRAME_BYTES*8  response frame; held stable from the trigger until tx_ready returns high
- cop_valid  out  1  coprocessor request valid
- cop_ready  in  1  coprocessor accepts the request
- cop_op  out  8  sub-operation, taken from request byte 1
- cop_operand  out  (FRAME_BYTES-2)*8  request bytes 2..17
- cop_done  in  1  one-cycle result strobe
- cop_result  in  (FRAME_BYTES-2)*8  result payload, sampled on cop_done
- busy  out  1  high in any state other than IDLE
- frames_ok  out  CNT_W  count of successful responses
- frames_err  out  CNT_W  count of error responses

Behaviour:
- Reset: state=IDLE. rx_pop, tx_trigger, cop_valid, busy = 0. tx_frame, cop_op, cop_operand, frames_ok, frames_err = 0. A reset taken mid-operation abandons the transaction with no trigger and no pop.
- IDLE: when rx_empty=0, latch rx_frame into the request register, pulse rx_pop for one cycle, go to DECODE. Only one frame is popped per transaction.
- DECODE (1 cycle), by opcode:
  - 0x01 ECHO: response = request unchanged.
  - 0x02 COMPUTE: go to DISPATCH.
  - 0x03 STATUS: byte0=0x83, byte1=request byte1 (tag), bytes2-3=frames_ok (LSB first), bytes4-5=frames_err, remaining bytes 0.
  - Any other opcode: error response byte0=0xEE, byte1=offending opcode, remaining bytes 0.
- DISPATCH: assert cop_valid with cop_op and cop_operand stable. Hold until the cycle with cop_valid&&cop_ready, then drop cop_valid and go to WAIT_RESULT. The timeout counter starts when DISPATCH is entered.
- WAIT_RESULT:
  - cop_done → response byte0=0x82, byte1=cop_op, bytes2-17=cop_result.
  - Timeout counter reaches TIMEOUT_CYCLES-1, in DISPATCH or WAIT_RESULT → response byte0=0xEF, byte1=0x02, remaining bytes 0; cop_valid is dropped.
  - If cop_done and the timeout occur in the same cycle, cop_done wins.
  - A cop_done arriving outside WAIT_RESULT is ignored.
- SEND: wait for tx_ready=1, then pulse tx_trigger for one cycle with tx_frame registered that cycle. Go to WAIT_TX.
- WAIT_TX: wait one cycle for tx_ready to drop, or for tx_ready to be low in any later cycle; then return to IDLE. This guards against double triggering.
- Counters:
  - Successful responses (ECHO, STATUS, 0x82) increment frames_ok at the trigger pulse.
  - Error responses (0xE*) increment frames_err at the trigger pulse.
  - Both counters saturate at all-ones and never wrap.
  - STATUS reports the counts as they stood before its own increment.
- Latency: ECHO/STATUS take rx_pop→tx_trigger = 3 cycles when tx_ready is already high (POP, DECODE, SEND).

Optional Feature:
CMD_SEQ_CHECKSUM_EN
- Defined:
  - Request byte 17 must equal the XOR of bytes 0..16. On mismatch the response is byte0=0xEC, byte1=received checksum, remaining bytes 0; it counts as an error and the opcode is not executed.
  - Every response has byte 17 overwritten with the XOR of its bytes 0..16.
  - For COMPUTE, cop_operand byte 15 carries the checksum byte unchanged.
- Undefined: byte 17 is ordinary payload; no check is made and no overwrite is applied.

Decomposition:
- Package uart_cmd_pkg holds:
  - Opcode constants: OP_ECHO=0x01, OP_COMPUTE=0x02, OP_STATUS=0x03.
  - Response codes: RSP_COMPUTE=0x82, RSP_STATUS=0x83, RSP_BADOP=0xEE, RSP_TIMEOUT=0xEF, RSP_BADSUM=0xEC.
  - The state enum and the FRAME_BYTES default.
- Sub-module uart_frame_xor: a combinational XOR reduction of bytes 0..FRAME_BYTES-2, instantiated once for checking and once for generating. It is present only under CMD_SEQ_CHECKSUM_EN.

Test Plan:
- ECHO: rx_frame byte0=0x01, bytes1..17=0x10..0x20, tx_ready=1 → exactly one rx_pop, tx_trigger 3 cycles later, tx_frame equals the request, frames_ok=1.
- COMPUTE: byte0=0x02, byte1=0x05. Coprocessor holds cop_ready low for 4 cycles, then asserts cop_done with result 0xA5 repeated → one accepted handshake, response byte0=0x82, byte1=0x05, bytes2-17=0xA5.
- Timeout: TIMEOUT_CYCLES=16, COMPUTE with cop_done never asserted → response 0xEF/0x02, frames_err=1, cop_valid low afterward; a later stray cop_done is ignored.
- Bad opcode 0x7F, then STATUS with tag 0x33 → response 0xEE/0x7F, then 0x83/0x33 with bytes2-3=0x0000 and bytes4-5=0x0001.
- Back-to-back frames with tx_ready low for 20 cycles → no trigger while tx_ready is low, one trigger per frame, second frame popped only after WAIT_TX. A reset asserted during WAIT_RESULT → all outputs return to their reset values, no tx_trigger.
- With CMD_SEQ_CHECKSUM_EN: ECHO with a wrong byte 17 → 0xEC response whose byte 17 is the correct XOR; a correct checksum → echo returned.
